// File: rtl/expipe_pkg.sv
// Shared execution-pipe types for the FP execution-unit front-end: tags, flags,
// exception codes, front-end state and queue entry layout.
package expipe_pkg;

    localparam int ROB_IDX_W      = 5;
    localparam int FPU_EU_FLEN    = 64;
    localparam int FPU_EU_CTL_LEN = 6;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fcsr_fflags_t;

    typedef enum logic [4:0] {
        E_ILLEGAL_INSTRUCTION = 5'd2,
        E_UNKNOWN             = 5'd31
    } except_code_t;

    typedef enum logic {
        RUN,
        DRAIN
    } fpu_eu_state_t;

    localparam logic [2:0] FRM_DYN  = 3'b111;
    localparam logic [2:0] FRM_RSV0 = 3'b101;
    localparam logic [2:0] FRM_RSV1 = 3'b110;

    typedef struct packed {
        logic [3*FPU_EU_FLEN-1:0]   ops;
        logic [FPU_EU_CTL_LEN-1:0]  ctl;
        logic [2:0]                 rm;
        rob_idx_t                   rob_idx;
        logic                       illegal;
    } fpu_eu_entry_t;

    // A resolved mode can never legally be DYN; it only names "use frm".
    function automatic logic rm_is_illegal(input logic [2:0] rm);
        return (rm == FRM_RSV0) || (rm == FRM_RSV1) || (rm == FRM_DYN);
    endfunction

endpackage

// File: rtl/fpu_eu_queue.sv
// Circular FIFO with synchronous flush; pointers wrap at DEPTH-1 so any depth works.
module fpu_eu_queue
    import expipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fpu_eu_ctrl.sv
// FP execution-unit front-end: queues issued ops, resolves rounding mode, bounds
// in-flight ops and drains stale results after a flush. Option: FPU_EU_FFLAGS_ACC_EN.
//
//   state | meaning
//   RUN   | issue legal head ops, pass results to the CDB, retire illegal heads
//   DRAIN | post-flush: swallow returning results until nothing is in flight
module fpu_eu_ctrl
    import expipe_pkg::*;
#(
    parameter int EU_CTL_LEN   = 6,
    parameter int FLEN         = 64,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [EU_CTL_LEN-1:0] ctl_i,
    input  logic [2:0]            rm_i,
    input  logic [2:0]            frm_i,
    input  rob_idx_t              rob_idx_i,
    input  logic [FLEN-1:0]       rs1_value_i,
    input  logic [FLEN-1:0]       rs2_value_i,
    input  logic [FLEN-1:0]       rs3_value_i,
    output logic                  fpu_valid_o,
    input  logic                  fpu_ready_i,
    output logic [EU_CTL_LEN-1:0] fpu_ctl_o,
    output logic [2:0]            fpu_rm_o,
    output rob_idx_t              fpu_tag_o,
    output logic [3*FLEN-1:0]     fpu_ops_o,
    input  logic                  fpu_valid_i,
    output logic                  fpu_ready_o,
    input  logic [FLEN-1:0]       fpu_result_i,
    input  rob_idx_t              fpu_tag_i,
    input  fcsr_fflags_t          fpu_status_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output rob_idx_t              rob_idx_o,
    output logic [FLEN-1:0]       result_o,
    output logic                  except_raised_o,
    output except_code_t          except_code_o,
`ifdef FPU_EU_FFLAGS_ACC_EN
    input  logic                  fflags_clr_i,
    output fcsr_fflags_t          fflags_acc_o,
`endif
    output fcsr_fflags_t          fflags_o
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [3*FLEN-1:0]     ops;
        logic [EU_CTL_LEN-1:0] ctl;
        logic [2:0]            rm;
        rob_idx_t              rob_idx;
        logic                  illegal;
    } entry_t;

    entry_t        wr_entry;
    entry_t        head;
    logic          q_empty;
    logic          q_full;
    logic          q_pop;
    logic [2:0]    rm_res;
    fpu_eu_state_t state;
    logic [IW-1:0] inflight;
    logic [IW-1:0] inflight_nxt;
    logic          issue_hs;
    logic          resp_hs;
    logic          resp_pass;
    logic          illegal_ret;

    assign rm_res = (rm_i == FRM_DYN) ? frm_i : rm_i;

    always_comb begin
        wr_entry.ops     = {rs3_value_i, rs2_value_i, rs1_value_i};
        wr_entry.ctl     = ctl_i;
        wr_entry.rm      = rm_res;
        wr_entry.rob_idx = rob_idx_i;
        wr_entry.illegal = rm_is_illegal(rm_res);
    end

    fpu_eu_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush_i),
        .push  (valid_i && ready_o),
        .pop   (q_pop),
        .wdata (wr_entry),
        .rdata (head),
        .empty (q_empty),
        .full  (q_full)
    );

    assign ready_o     = !q_full;
    assign fpu_valid_o = (state == RUN) && !q_empty && !head.illegal
                         && (inflight < IW'(MAX_INFLIGHT));
    assign fpu_ctl_o   = head.ctl;
    assign fpu_rm_o    = head.rm;
    assign fpu_tag_o   = head.rob_idx;
    assign fpu_ops_o   = head.ops;

    // Datapath results win the CDB; an illegal head only retires in an idle slot.
    assign resp_pass   = (state == RUN) && !flush_i && fpu_valid_i;
    assign illegal_ret = (state == RUN) && !flush_i && !fpu_valid_i
                         && !q_empty && head.illegal;
    assign fpu_ready_o = (state == DRAIN) || flush_i || ready_i;
    assign valid_o     = resp_pass || illegal_ret;

    always_comb begin
        rob_idx_o       = '0;
        result_o        = '0;
        fflags_o        = '0;
        except_raised_o = 1'b0;
        except_code_o   = E_UNKNOWN;
        if (resp_pass) begin
            rob_idx_o = fpu_tag_i;
            result_o  = fpu_result_i;
            fflags_o  = fpu_status_i;
        end else if (illegal_ret) begin
            rob_idx_o       = head.rob_idx;
            except_raised_o = 1'b1;
            except_code_o   = E_ILLEGAL_INSTRUCTION;
        end
    end

    assign issue_hs = fpu_valid_o && fpu_ready_i;
    assign resp_hs  = fpu_valid_i && fpu_ready_o;
    assign q_pop    = issue_hs || (illegal_ret && ready_i);

    always_comb begin
        inflight_nxt = inflight;
        if (issue_hs && !resp_hs)
            inflight_nxt = inflight + IW'(1);
        else if (!issue_hs && resp_hs && (inflight != '0))
            inflight_nxt = inflight - IW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            inflight <= '0;
        end else begin
            inflight <= inflight_nxt;
            unique case (state)
                RUN:   if (flush_i && (inflight_nxt != '0)) state <= DRAIN;
                DRAIN: if (inflight_nxt == '0) state <= RUN;
            endcase
        end
    end

`ifdef FPU_EU_FFLAGS_ACC_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            fflags_acc_o <= '0;
        else if (fflags_clr_i)
            fflags_acc_o <= '0;
        else if (valid_o && ready_i)
            fflags_acc_o <= fcsr_fflags_t'(fflags_acc_o | fflags_o);
    end
`endif

endmodule

// File: tb/tb_fpu_eu_ctrl.sv
// Randomized scoreboard bench for fpu_eu_ctrl with a latency-3 in-order datapath stub.
module tb_fpu_eu_ctrl;
    import expipe_pkg::*;

    localparam int CTL   = 6;
    localparam int FL    = 64;
    localparam int DEPTH = 4;
    localparam int MAXI  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i, flush_i, valid_i, ready_o;
    logic [CTL-1:0]   ctl_i;
    logic [2:0]       rm_i, frm_i;
    rob_idx_t         rob_idx_i;
    logic [FL-1:0]    rs1_value_i, rs2_value_i, rs3_value_i;
    logic             fpu_valid_o, fpu_ready_i;
    logic [CTL-1:0]   fpu_ctl_o;
    logic [2:0]       fpu_rm_o;
    rob_idx_t         fpu_tag_o;
    logic [3*FL-1:0]  fpu_ops_o;
    logic             fpu_valid_i, fpu_ready_o;
    logic [FL-1:0]    fpu_result_i;
    rob_idx_t         fpu_tag_i;
    fcsr_fflags_t     fpu_status_i;
    logic             ready_i, valid_o;
    rob_idx_t         rob_idx_o;
    logic [FL-1:0]    result_o;
    logic             except_raised_o;
    except_code_t     except_code_o;
    fcsr_fflags_t     fflags_o;
`ifdef FPU_EU_FFLAGS_ACC_EN
    logic             fflags_clr_i;
    fcsr_fflags_t     fflags_acc_o;
`endif

    fpu_eu_ctrl #(
        .EU_CTL_LEN   (CTL),
        .FLEN         (FL),
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .ctl_i           (ctl_i),
        .rm_i            (rm_i),
        .frm_i           (frm_i),
        .rob_idx_i       (rob_idx_i),
        .rs1_value_i     (rs1_value_i),
        .rs2_value_i     (rs2_value_i),
        .rs3_value_i     (rs3_value_i),
        .fpu_valid_o     (fpu_valid_o),
        .fpu_ready_i     (fpu_ready_i),
        .fpu_ctl_o       (fpu_ctl_o),
        .fpu_rm_o        (fpu_rm_o),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_ops_o       (fpu_ops_o),
        .fpu_valid_i     (fpu_valid_i),
        .fpu_ready_o     (fpu_ready_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_tag_i       (fpu_tag_i),
        .fpu_status_i    (fpu_status_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .rob_idx_o       (rob_idx_o),
        .result_o        (result_o),
        .except_raised_o (except_raised_o),
        .except_code_o   (except_code_o),
`ifdef FPU_EU_FFLAGS_ACC_EN
        .fflags_clr_i    (fflags_clr_i),
        .fflags_acc_o    (fflags_acc_o),
`endif
        .fflags_o        (fflags_o)
    );

    typedef struct {
        logic [63:0] r1, r2, r3;
        logic [5:0]  ctl;
        logic [2:0]  rm;
        logic [4:0]  tag;
        bit          ill;
    } ent_t;

    typedef struct {
        ent_t e;
        bit   stale;
    } inf_t;

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] res;
        logic [4:0]  fl;
        int          rdy;
    } stub_t;

    ent_t  mq[$];     // accepted, not yet issued or retired
    inf_t  infq[$];   // issued to the datapath, awaiting a response
    stub_t sq[$];     // datapath stub pipeline contents

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_res = 0, n_ill = 0, n_drop = 0;
    logic [4:0] acc_m = '0;

    function automatic logic [63:0] fres(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
        return (a + b) ^ {c[31:0], c[63:32]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: samples one time unit before each rising edge.
    ent_t       e, e2;
    bit         draining, exp_fv, exp_ill, exp_vo, issue, resp, can_push;
    logic [4:0] ex_fl;
    logic [2:0] rres;
    always begin : monitor
        @(negedge clk);
        #4;
        cyc++;
        if (rst_i) begin
            chk("rst_valid_o", 64'(valid_o), 64'(0));
            chk("rst_fpu_valid_o", 64'(fpu_valid_o), 64'(0));
            chk("rst_ready_o", 64'(ready_o), 64'(1));
            chk("rst_except_raised", 64'(except_raised_o), 64'(0));
            chk("rst_except_code", 64'(except_code_o), 64'(E_UNKNOWN));
            chk("rst_fflags_o", 64'(fflags_o), 64'(0));
`ifdef FPU_EU_FFLAGS_ACC_EN
            chk("rst_fflags_acc", 64'(fflags_acc_o), 64'(0));
`endif
            mq.delete();
            infq.delete();
            sq.delete();
            acc_m = '0;
        end else begin
            draining = 1'b0;
            foreach (infq[i]) if (infq[i].stale) draining = 1'b1;
            can_push = (mq.size() < DEPTH);
            chk("ready_o", 64'(ready_o), 64'(can_push));
            exp_fv = !draining && (mq.size() > 0) && !mq[0].ill && (infq.size() < MAXI);
            chk("fpu_valid_o", 64'(fpu_valid_o), 64'(exp_fv));
            chk("fpu_ready_o", 64'(fpu_ready_o), 64'(draining || flush_i || ready_i));
            exp_ill = !draining && !flush_i && !fpu_valid_i && (mq.size() > 0) && mq[0].ill;
            exp_vo  = (fpu_valid_i && !draining && !flush_i) || exp_ill;
            chk("valid_o", 64'(valid_o), 64'(exp_vo));
            issue = fpu_valid_o && fpu_ready_i;
            resp  = fpu_valid_i && fpu_ready_o;
            ex_fl = '0;

            if (issue && exp_fv) begin
                e = mq[0];
                chk("fpu_rm_o", 64'(fpu_rm_o), 64'(e.rm));
                chk("fpu_tag_o", 64'(fpu_tag_o), 64'(e.tag));
                chk("fpu_ctl_o", 64'(fpu_ctl_o), 64'(e.ctl));
                chk("fpu_ops_rs1", fpu_ops_o[63:0], e.r1);
                chk("fpu_ops_rs2", fpu_ops_o[127:64], e.r2);
                chk("fpu_ops_rs3", fpu_ops_o[191:128], e.r3);
            end

            if (valid_o && exp_vo) begin
                if (fpu_valid_i) begin
                    if (infq.size() == 0) begin
                        chk("resp_has_issue", 64'(0), 64'(1));
                    end else begin
                        e = infq[0].e;
                        ex_fl = e.ctl[4:0];
                        chk("res_rob_idx", 64'(rob_idx_o), 64'(e.tag));
                        chk("res_result", result_o, fres(e.r1, e.r2, e.r3));
                        chk("res_fflags", 64'(fflags_o), 64'(ex_fl));
                        chk("res_except", 64'(except_raised_o), 64'(0));
                        chk("res_code", 64'(except_code_o), 64'(E_UNKNOWN));
                        if (ready_i) n_res++;
                    end
                end else begin
                    e = mq[0];
                    chk("ill_rob_idx", 64'(rob_idx_o), 64'(e.tag));
                    chk("ill_result", result_o, 64'(0));
                    chk("ill_fflags", 64'(fflags_o), 64'(0));
                    chk("ill_except", 64'(except_raised_o), 64'(1));
                    chk("ill_code", 64'(except_code_o), 64'(E_ILLEGAL_INSTRUCTION));
                    if (ready_i) n_ill++;
                end
            end

`ifdef FPU_EU_FFLAGS_ACC_EN
            chk("fflags_acc", 64'(fflags_acc_o), 64'(acc_m));
            if (fflags_clr_i) acc_m = '0;
            else if (valid_o && ready_i && exp_vo) acc_m = acc_m | ex_fl;
`endif

            if (resp) begin
                if (sq.size() > 0) void'(sq.pop_front());
                if (infq.size() > 0) begin
                    if (infq[0].stale || flush_i) n_drop++;
                    void'(infq.pop_front());
                end
            end
            if (issue) begin
                sq.push_back('{tag: fpu_tag_o,
                               res: fres(fpu_ops_o[63:0], fpu_ops_o[127:64], fpu_ops_o[191:128]),
                               fl: fpu_ctl_o[4:0], rdy: cyc + 3});
                if (exp_fv) begin
                    e2 = mq.pop_front();
                    infq.push_back('{e: e2, stale: 1'b0});
                end
            end
            if (exp_ill && ready_i) void'(mq.pop_front());
            if (valid_i && can_push) begin
                rres = (rm_i == 3'b111) ? frm_i : rm_i;
                mq.push_back('{r1: rs1_value_i, r2: rs2_value_i, r3: rs3_value_i,
                               ctl: ctl_i, rm: rres, tag: rob_idx_i, ill: (rres >= 3'd5)});
            end
            if (flush_i) begin
                mq.delete();
                foreach (infq[i]) infq[i].stale = 1'b1;
            end
        end
    end

    task automatic step(input int pp, input int pf, input int pr, input int pfl, input bit r);
        @(negedge clk);
        rst_i   = r;
        flush_i = !r && ($urandom_range(99) < pfl);
        valid_i = !r && ($urandom_range(99) < pp);
        ctl_i   = CTL'($urandom);
        case ($urandom_range(9))
            0, 1, 2: rm_i = 3'b111;
            3:       rm_i = 3'($urandom_range(6, 5));
            default: rm_i = 3'($urandom_range(4));
        endcase
        frm_i       = ($urandom_range(3) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4));
        rob_idx_i   = 5'($urandom);
        rs1_value_i = {$urandom, $urandom};
        rs2_value_i = {$urandom, $urandom};
        rs3_value_i = {$urandom, $urandom};
        fpu_ready_i = ($urandom_range(99) < pf);
        ready_i     = ($urandom_range(99) < pr);
`ifdef FPU_EU_FFLAGS_ACC_EN
        fflags_clr_i = ($urandom_range(99) < 4);
`endif
        if (!r && (sq.size() > 0) && (sq[0].rdy <= cyc)) begin
            fpu_valid_i  = 1'b1;
            fpu_result_i = sq[0].res;
            fpu_tag_i    = sq[0].tag;
            fpu_status_i = fcsr_fflags_t'(sq[0].fl);
        end else begin
            fpu_valid_i  = 1'b0;
            fpu_result_i = '0;
            fpu_tag_i    = '0;
            fpu_status_i = '0;
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ctl_i = '0; rm_i = '0; frm_i = '0;
        rob_idx_i = '0; rs1_value_i = '0; rs2_value_i = '0; rs3_value_i = '0;
        fpu_ready_i = 1'b0; fpu_valid_i = 1'b0; fpu_result_i = '0; fpu_tag_i = '0;
        fpu_status_i = '0; ready_i = 1'b0;
`ifdef FPU_EU_FFLAGS_ACC_EN
        fflags_clr_i = 1'b0;
`endif
        repeat (3)    step(0, 100, 100, 0, 1'b1);
        repeat (300)  step(95, 100, 100, 0, 1'b0);
        repeat (1500) step(60, 70, 70, 3, 1'b0);
        repeat (2)    step(80, 80, 80, 0, 1'b1);
        repeat (500)  step(60, 70, 70, 3, 1'b0);
        repeat (80)   step(0, 100, 100, 0, 1'b0);
        @(negedge clk);
        #6;
        chk("end_queue_empty", 64'(mq.size()), 64'(0));
        chk("end_inflight_empty", 64'(infq.size()), 64'(0));
        chk("results_seen", 64'(n_res > 100), 64'(1));
        chk("illegal_seen", 64'(n_ill > 5), 64'(1));
        chk("drops_seen", 64'(n_drop > 0), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
